// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and helpers for the set access controller:
//               FSM state encoding and a one-hot to index conversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_EVICT_WAIT = 3'd2,
    ST_WRITEBACK  = 3'd3,
    ST_FILL       = 3'd4,
    ST_ALLOCATE   = 3'd5,
    ST_RESPOND    = 3'd6
  } cache_state_e;

  localparam int MAX_WAYS = 32;

  // Index of the lowest set bit; a zero vector maps to index 0.
  function automatic logic [4:0] onehot_to_idx(input logic [MAX_WAYS-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[4:0];
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/set_tag_match.sv
// ============================================================================
// Module      : set_tag_match
// Description : Combinational tag compare across all ways of one set.
//               Produces the per-way hit vector, the lowest matching index,
//               and a flag for more than one match (corrupt set state).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_tag_match #(
  parameter int NUM_WAYS  = 8,
  parameter int TAG_WIDTH = 20,
  localparam int IDX_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tags,
  input  logic [NUM_WAYS-1:0]                valid,
  input  logic [TAG_WIDTH-1:0]               tag,
  output logic [NUM_WAYS-1:0]                hit_vec,
  output logic                               hit_any,
  output logic                               hit_multi,
  output logic [IDX_W-1:0]                   hit_idx
);

  genvar g;
  generate
    for (g = 0; g < NUM_WAYS; g++) begin : g_cmp
      assign hit_vec[g] = valid[g] && (tags[g] == tag);
    end
  endgenerate

  assign hit_any   = |hit_vec;
  // Clearing the lowest set bit leaves something only if two or more matched.
  assign hit_multi = |(hit_vec & (hit_vec - NUM_WAYS'(1)));

  // Lowest-index match wins.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/set_access_controller.sv
// ============================================================================
// Module      : set_access_controller
// Description : Single-set cache access controller. Looks up a request tag,
//               on a miss obtains a victim (free way or from the replacement
//               policy), writes back dirty victims, fills and allocates,
//               then responds with hit flag and accessed way.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_access_controller
  import cache_pkg::*;
#(
  parameter int NUM_WAYS  = 8,
  parameter int TAG_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 req_write,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [NUM_WAYS-1:0]  resp_way,
  output logic [NUM_WAYS-1:0]  hit_way,
  output logic [NUM_WAYS-1:0]  allocate_way,
  output logic                 evict_req,
  input  logic                 eviction_ready,
  input  logic [NUM_WAYS-1:0]  eviction_target,
  output logic                 wb_valid,
  output logic [TAG_WIDTH-1:0] wb_tag,
  input  logic                 wb_ready,
  output logic                 fill_valid,
  output logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 fill_ready,
  output logic                 protocol_err
);

  localparam int IDX_W = $clog2(NUM_WAYS);

  cache_state_e r_state, w_next;

  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] r_tags;
  logic [NUM_WAYS-1:0]                r_valid;
  logic [NUM_WAYS-1:0]                r_dirty;
  logic [TAG_WIDTH-1:0]               r_cap_tag;
  logic                               r_cap_write;
  logic [IDX_W-1:0]                   r_way;
  logic                               r_hit;
  logic                               r_perr;

  logic [NUM_WAYS-1:0] w_hit_vec;
  logic [NUM_WAYS-1:0] w_hit_oh;
  logic                w_hit_any;
  logic                w_hit_multi;
  logic [IDX_W-1:0]    w_hit_idx;
  logic                w_inv_any;
  logic [IDX_W-1:0]    w_inv_idx;
  logic [IDX_W-1:0]    w_tgt_idx;
  logic                w_tgt_zero;
  logic [NUM_WAYS-1:0] w_way_oh;

  set_tag_match #(
    .NUM_WAYS  (NUM_WAYS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_match (
    .tags      (r_tags),
    .valid     (r_valid),
    .tag       (r_cap_tag),
    .hit_vec   (w_hit_vec),
    .hit_any   (w_hit_any),
    .hit_multi (w_hit_multi),
    .hit_idx   (w_hit_idx)
  );

  // Isolate the lowest matching way so hit_way stays one-hot on corrupt state.
  assign w_hit_oh   = w_hit_vec & ~(w_hit_vec - NUM_WAYS'(1));
  assign w_tgt_idx  = IDX_W'(onehot_to_idx(MAX_WAYS'(eviction_target)));
  assign w_tgt_zero = ~|eviction_target;
  assign w_way_oh   = NUM_WAYS'(1) << r_way;
  assign protocol_err = r_perr;

  // Lowest-index invalid way, used as the victim when the set is not full.
  always_comb begin
    w_inv_any = ~&r_valid;
    w_inv_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_inv_idx = IDX_W'(i);
    end
  end

  // State register; async reset drops all handshake outputs immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    hit_way      = '0;
    allocate_way = '0;
    evict_req    = 1'b0;
    wb_valid     = 1'b0;
    wb_tag       = '0;
    fill_valid   = 1'b0;
    fill_tag     = '0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    resp_way     = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_hit_any) begin
          hit_way = w_hit_oh;
          w_next  = ST_RESPOND;
        end else if (w_inv_any) begin
          w_next = ST_FILL;
        end else begin
          w_next = ST_EVICT_WAIT;
        end
      end
      ST_EVICT_WAIT: begin
        evict_req = 1'b1;
        if (eviction_ready) w_next = r_dirty[w_tgt_idx] ? ST_WRITEBACK : ST_FILL;
      end
      ST_WRITEBACK: begin
        wb_valid = 1'b1;
        wb_tag   = r_tags[r_way];
        if (wb_ready) w_next = ST_FILL;
      end
      ST_FILL: begin
        fill_valid = 1'b1;
        fill_tag   = r_cap_tag;
        if (fill_ready) w_next = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        allocate_way = w_way_oh;
        w_next       = ST_RESPOND;
      end
      ST_RESPOND: begin
        resp_valid = 1'b1;
        resp_hit   = r_hit;
        resp_way   = w_way_oh;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, way selection, valid/dirty bookkeeping, sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      r_cap_tag   <= '0;
      r_cap_write <= 1'b0;
      r_way       <= '0;
      r_hit       <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cap_tag   <= req_tag;
            r_cap_write <= req_write;
          end
        end
        ST_LOOKUP: begin
          r_hit <= w_hit_any;
          if (w_hit_multi) r_perr <= 1'b1;
          if (w_hit_any) begin
            r_way <= w_hit_idx;
            if (r_cap_write) r_dirty[w_hit_idx] <= 1'b1;
          end else begin
            r_way <= w_inv_idx;
          end
        end
        ST_EVICT_WAIT: begin
          if (eviction_ready) begin
            r_way <= w_tgt_idx;
            if (w_tgt_zero) r_perr <= 1'b1;
          end
        end
        ST_ALLOCATE: begin
          r_valid[r_way] <= 1'b1;
          r_dirty[r_way] <= r_cap_write;
        end
        default: ;
      endcase
    end
  end

  // Tag storage needs no reset: entries are meaningless until valid.
  always_ff @(posedge clk) begin
    if (r_state == ST_ALLOCATE) r_tags[r_way] <= r_cap_tag;
  end

endmodule

`default_nettype wire

// File: tb/tb_set_access_controller.sv
// ============================================================================
// Module      : tb_set_access_controller
// Description : Self-checking bench for set_access_controller (4 ways, 8-bit
//               tags) with directed scenarios and randomized accesses checked
//               against an array-based model of the set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_set_access_controller;

  localparam int NW = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [TW-1:0] req_tag = '0;
  logic          req_write = 1'b0;
  logic          resp_valid;
  logic          resp_hit;
  logic [NW-1:0] resp_way;
  logic [NW-1:0] hit_way;
  logic [NW-1:0] allocate_way;
  logic          evict_req;
  logic          eviction_ready = 1'b0;
  logic [NW-1:0] eviction_target = '0;
  logic          wb_valid;
  logic [TW-1:0] wb_tag;
  logic          wb_ready = 1'b0;
  logic          fill_valid;
  logic [TW-1:0] fill_tag;
  logic          fill_ready = 1'b0;
  logic          protocol_err;

  set_access_controller #(.NUM_WAYS(NW), .TAG_WIDTH(TW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_tag         (req_tag),
    .req_write       (req_write),
    .resp_valid      (resp_valid),
    .resp_hit        (resp_hit),
    .resp_way        (resp_way),
    .hit_way         (hit_way),
    .allocate_way    (allocate_way),
    .evict_req       (evict_req),
    .eviction_ready  (eviction_ready),
    .eviction_target (eviction_target),
    .wb_valid        (wb_valid),
    .wb_tag          (wb_tag),
    .wb_ready        (wb_ready),
    .fill_valid      (fill_valid),
    .fill_tag        (fill_tag),
    .fill_ready      (fill_ready),
    .protocol_err    (protocol_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model of the set contents.
  logic [TW-1:0] m_tag   [NW];
  bit            m_valid [NW];
  bit            m_dirty [NW];
  bit            m_perr;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_perr = 1'b0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    eviction_ready = 1'b0;
    wb_ready       = 1'b0;
    fill_ready     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // One complete access. Called at posedge+1 with the DUT idle.
  // edly: cycle of evict_req in which eviction_ready is given (>=1);
  // wdly/fdly: cycles of wb_ready/fill_ready held low before granting.
  task automatic access(input logic [TW-1:0] tag, input bit wr, input logic [NW-1:0] tgt,
                        input int edly, input int wdly, input int fdly);
    int way, k, lat, ecnt, wcnt, fcnt, wtag_bad, ftag_bad, hit_k, exp_lat;
    bit hit, ev, wb, got;
    logic [TW-1:0] exp_wbtag;
    logic [NW-1:0] seen_hit, seen_alloc, r_way;
    bit r_hit;

    // Predict from the model.
    way = -1; ev = 0; wb = 0; exp_wbtag = '0;
    for (int i = NW - 1; i >= 0; i--) if (m_valid[i] && m_tag[i] == tag) way = i;
    hit = (way >= 0);
    if (hit) begin
      if (wr) m_dirty[way] = 1'b1;
    end else begin
      for (int i = NW - 1; i >= 0; i--) if (!m_valid[i]) way = i;
      if (way < 0) begin
        ev = 1;
        way = 0;
        if (tgt == '0) m_perr = 1'b1;
        else for (int i = NW - 1; i >= 0; i--) if (tgt[i]) way = i;
        wb = m_dirty[way];
        exp_wbtag = m_tag[way];
      end
      m_tag[way] = tag; m_valid[way] = 1'b1; m_dirty[way] = wr;
    end
    exp_lat = hit ? 2 : 2 + (ev ? edly : 0) + (wb ? wdly + 1 : 0) + fdly + 1 + 1;

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_tag = tag; req_write = wr;
    @(posedge clk); #1;
    req_valid = 1'b0; req_tag = $urandom; req_write = $urandom;

    k = 1; lat = 0; ecnt = 0; wcnt = 0; fcnt = 0; wtag_bad = 0; ftag_bad = 0;
    hit_k = 0; got = 0; seen_hit = '0; seen_alloc = '0; r_way = '0; r_hit = 0;
    while (k <= 60 && !got) begin
      chk("req_ready_busy", req_ready, 0);
      chk("exclusive", ((hit_way != '0) + (allocate_way != '0) + evict_req) <= 1, 1);
      chk("onehot", ($countones(hit_way) <= 1) && ($countones(allocate_way) <= 1), 1);
      if (hit_way != '0) begin seen_hit = hit_way; hit_k = k; end
      if (allocate_way != '0) seen_alloc = allocate_way;
      if (evict_req) begin
        ecnt++;
        eviction_ready = (ecnt == edly);
        eviction_target = eviction_ready ? tgt : NW'($urandom);
      end else begin
        eviction_ready = $urandom;
        eviction_target = NW'($urandom);
      end
      if (wb_valid) begin
        wcnt++;
        if (wb_tag !== exp_wbtag) wtag_bad++;
        wb_ready = (wcnt > wdly);
      end else wb_ready = $urandom;
      if (fill_valid) begin
        fcnt++;
        if (fill_tag !== tag) ftag_bad++;
        fill_ready = (fcnt > fdly);
      end else fill_ready = $urandom;
      if (resp_valid) begin
        got = 1; lat = k; r_hit = resp_hit; r_way = resp_way;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    eviction_ready = 1'b0; wb_ready = 1'b0; fill_ready = 1'b0;

    chk("resp_seen", got, 1);
    chk("resp_hit", r_hit, hit);
    chk("resp_way", r_way, NW'(1) << way);
    chk("latency", lat, exp_lat);
    chk("hit_way", seen_hit, hit ? NW'(1) << way : '0);
    chk("hit_way_cycle", hit_k, hit ? 1 : 0);
    chk("allocate_way", seen_alloc, hit ? '0 : NW'(1) << way);
    chk("evict_cycles", ecnt, ev ? edly : 0);
    chk("wb_cycles", wcnt, wb ? wdly + 1 : 0);
    chk("wb_tag", wtag_bad, 0);
    chk("fill_cycles", fcnt, hit ? 0 : fdly + 1);
    chk("fill_tag", ftag_bad, 0);
    chk("protocol_err", protocol_err, m_perr);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [NW-1:0] t;
    model_clear();

    // Outputs while held in reset.
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outputs", {resp_valid, resp_hit, resp_way, hit_way, allocate_way, evict_req,
                        wb_valid, wb_tag, fill_valid, fill_tag, protocol_err}, 0);
    do_reset();
    chk("post_rst_req_ready", req_ready, 1);

    // Cold fill: four misses into ways 0..3, no eviction.
    for (int i = 0; i < 4; i++) access(8'h10 + 8'(i), 0, 4'b0000, 1, 0, 0);
    // Hit on way 2.
    access(8'h12, 0, 4'b0000, 1, 0, 0);
    // Full-set miss, policy answers on the third evict_req cycle.
    access(8'h20, 0, 4'b0010, 3, 0, 0);

    // Dirty eviction with stalled write-back.
    do_reset();
    for (int i = 0; i < 4; i++) access(8'h10 + 8'(i), 0, 4'b0000, 1, 0, 0);
    access(8'h11, 1, 4'b0000, 1, 0, 0);
    access(8'h30, 0, 4'b0010, 1, 2, 1);

    // Zero target: way 0 replaced, sticky error, cleared only by reset.
    access(8'h40, 0, 4'b0000, 1, 0, 0);
    access(8'h40, 0, 4'b0000, 1, 0, 0);
    access(8'h41, 0, 4'b0110, 2, 0, 0);
    do_reset();
    chk("perr_cleared", protocol_err, 0);

    // Reset while a fill is stalled.
    access(8'h10, 0, 4'b0000, 1, 0, 0);
    req_valid = 1'b1; req_tag = 8'h55; req_write = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; fill_ready = 1'b0;
    n = 0;
    while (!fill_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("fill_before_rst", fill_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_others", {evict_req, wb_valid, resp_valid, protocol_err}, 0);
    do_reset();
    access(8'h10, 0, 4'b0000, 1, 0, 0);

    // Randomized accesses over a small tag pool to mix hits, misses, evictions.
    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 9);
      if (n == 0)      t = 4'b0000;
      else if (n < 3)  t = NW'($urandom);
      else             t = 4'b0001 << $urandom_range(0, 3);
      access(8'h10 + 8'($urandom_range(0, 6)), 1'($urandom), t,
             $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/set_access_controller.md
SET_ACCESS_CONTROLLER -- requirements
Module: set_access_controller

Interface
REQ-001 The block SHALL have parameter NUM_WAYS, default 8, meaning ways per set (power of two, >=2).
REQ-002 The block SHALL have parameter TAG_WIDTH, default 20, meaning stored tag width.
REQ-003 The block SHALL have ports: clk  in  1  clock; reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Request ports SHALL be: req_valid in 1; req_ready out 1; req_tag in TAG_WIDTH; req_write in 1 (store access).
REQ-005 Response ports SHALL be: resp_valid out 1; resp_hit out 1; resp_way out NUM_WAYS (one-hot).
REQ-006 Policy-initiator ports SHALL be: hit_way out NUM_WAYS; allocate_way out NUM_WAYS; evict_req out 1; eviction_ready in 1; eviction_target in NUM_WAYS (one-hot victim).
REQ-007 Memory ports SHALL be: wb_valid out 1; wb_tag out TAG_WIDTH; wb_ready in 1; fill_valid out 1; fill_tag out TAG_WIDTH; fill_ready in 1; protocol_err out 1 (sticky).

Function
REQ-008 Per-way state SHALL be tag[TAG_WIDTH], valid, dirty, all held in registers.
REQ-009 FSM states SHALL be IDLE, LOOKUP, EVICT_WAIT, WRITEBACK, FILL, ALLOCATE, RESPOND.
REQ-010 IDLE: req_ready=1; req_valid&req_ready captures req_tag/req_write -> LOOKUP; req_ready=0 in every other state.
REQ-011 LOOKUP (one cycle): a hit is a valid way whose tag equals the captured tag.
REQ-012 On hit: hit_way=one-hot of hit way for exactly that cycle, dirty set if write -> RESPOND.
REQ-013 On miss with an invalid way: victim = lowest-index invalid way, no eviction request -> FILL.
REQ-014 On miss with all ways valid: -> EVICT_WAIT.
REQ-015 EVICT_WAIT: evict_req=1 every cycle until eviction_ready=1; the target is captured that cycle; evict_req=0 the next cycle.
REQ-016 eviction_ready while evict_req=0 SHALL be ignored.
REQ-017 A non-one-hot captured target SHALL select its lowest set bit.
REQ-018 A zero captured target SHALL select way 0 and set protocol_err.
REQ-019 After capture: victim dirty -> WRITEBACK, else -> FILL.
REQ-020 WRITEBACK: wb_valid=1, wb_tag=victim tag, both stable until wb_ready=1 -> FILL.
REQ-021 FILL: fill_valid=1, fill_tag=captured tag, stable until fill_ready=1 -> ALLOCATE.
REQ-022 ALLOCATE (one cycle): allocate_way=victim one-hot; victim tag=captured tag, valid=1, dirty=req_write -> RESPOND.
REQ-023 RESPOND (one cycle): resp_valid=1, resp_hit, resp_way=accessed way -> IDLE.
REQ-024 Latency: hit resp_valid 2 cycles after acceptance; clean miss with instant fill_ready, 4 cycles.
REQ-025 hit_way, allocate_way and evict_req SHALL never be nonzero in the same cycle; each is at most one-hot.
REQ-026 Multiple matching ways (corrupt state) SHALL resolve to the lowest index and set protocol_err.

Reset
REQ-027 Reset SHALL force IDLE and clear all valid and dirty bits; tags are don't-care.
REQ-028 Outputs on reset SHALL be: req_ready=1; all other outputs 0, including protocol_err.
REQ-029 Reset mid-operation SHALL abandon the transaction with no response.
REQ-030 Reset SHALL drop wb_valid, fill_valid and evict_req asynchronously.

Structure
REQ-031 Package cache_pkg SHALL hold the FSM state enum and a one-hot-to-index function.
REQ-032 Sub-module set_tag_match SHALL be combinational, producing a hit vector and a lowest-match index.

Verification (NUM_WAYS=4, TAG_WIDTH=8)
REQ-033 Fill cold set: reads 0x10,0x11,0x12,0x13 -> 4 misses, allocate_way 0001,0010,0100,1000, evict_req never asserted.
REQ-034 Hit: read 0x12 after fill -> hit_way=0100 at cycle+1, resp_valid/resp_hit=1, resp_way=0100 at cycle+2.
REQ-035 Full-set miss: read 0x20, eviction_ready after 3 cycles, target=0010 -> evict_req high exactly 3 cycles, then allocate_way=0010 with no wb_valid.
REQ-036 Dirty eviction: write 0x11 hit, then read 0x30 with target=0010 -> wb_valid, wb_tag=0x11 held through 2 cycles of wb_ready=0, then fill_tag=0x30.
REQ-037 Bad target: eviction_target=0000 with eviction_ready -> way 0 replaced, protocol_err=1 until reset.
REQ-038 Reset asserted during FILL -> fill_valid=0 immediately, req_ready=1, a subsequent read 0x10 misses.
